// File: rtl/fp_div.sv
// IEEE 754 single-precision divider: 26-cycle restoring mantissa divide, then
// normalize/round-to-nearest-even. Fixed 28-edge latency for every operand pair.
module fp_div #(
   parameter int width = 32  // only 32 is meaningful
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] result,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [25:0] rem_q, rem_d;
   logic [25:0] quo_q, quo_d;
   logic [31:0] stg_q, stg_d;
   logic        stg_dbz_q, stg_dbz_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;
   logic        dbz_q, dbz_d;

   // divide-step temporaries
   logic [25:0] mb, r_cur, r_sub;
   // normalize/round temporaries
   logic               sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic signed [9:0]  e;
   logic [23:0]        mant;
   logic [24:0]        mant_inc;
   logic               guard, sticky, inc;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      stg_d     = stg_q;
      stg_dbz_d = stg_dbz_q;
      result_d  = result_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;
      busy_d    = (state_q == DIVIDE) || (state_q == NORM);

      mb    = {3'b001, b_q[22:0]};
      // first step starts from the dividend mantissa, later steps from the running remainder
      r_cur = (cnt_q == 5'd0) ? {3'b001, a_q[22:0]} : rem_q;
      r_sub = r_cur - mb;

      sgn    = a_q[31] ^ b_q[31];
      a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
      b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
      a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
      b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
      a_zero = (a_q[30:23] == 8'h00);
      b_zero = (b_q[30:23] == 8'h00);

      e = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
      if (quo_q[25]) begin
         mant   = quo_q[25:2];
         guard  = quo_q[1];
         sticky = quo_q[0] | (|rem_q);
      end else begin
         mant   = quo_q[24:1];
         guard  = quo_q[0];
         sticky = |rem_q;
         e      = e - 10'sd1;
      end
      inc      = guard & (sticky | mant[0]);
      mant_inc = {1'b0, mant} + {24'd0, inc};
      if (mant_inc[24]) begin
         mant_inc = 25'h080_0000;
         e        = e + 10'sd1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               cnt_d   = 5'd0;
               quo_d   = 26'd0;
               rem_d   = 26'd0;
               state_d = DIVIDE;
            end
         end
         DIVIDE: begin
            if (r_cur >= mb) begin
               quo_d = {quo_q[24:0], 1'b1};
               rem_d = {r_sub[24:0], 1'b0};
            end else begin
               quo_d = {quo_q[24:0], 1'b0};
               rem_d = {r_cur[24:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd25) state_d = NORM;
         end
         NORM: begin
            stg_dbz_d = 1'b0;
            if (a_nan || b_nan)                         stg_d = QNAN;
            else if ((a_zero && b_zero) || (a_inf && b_inf)) stg_d = QNAN;
            else if (a_inf)                             stg_d = {sgn, 8'hFF, 23'd0};
            else if (b_inf || a_zero)                   stg_d = {sgn, 31'd0};
            else if (b_zero) begin
               stg_d     = {sgn, 8'hFF, 23'd0};
               stg_dbz_d = 1'b1;
            end
            else if (e >= 10'sd255)                     stg_d = {sgn, 8'hFF, 23'd0};
            else if (e <= 10'sd0)                       stg_d = {sgn, 31'd0};
            else                                        stg_d = {sgn, e[7:0], mant_inc[22:0]};
            state_d = DONE;
         end
         DONE: begin
            result_d = stg_q;
            dbz_d    = stg_dbz_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         rem_q     <= 26'd0;
         quo_q     <= 26'd0;
         stg_q     <= 32'd0;
         stg_dbz_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= 32'd0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         stg_q     <= stg_d;
         stg_dbz_q <= stg_dbz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 Parameter: width, 32, operand/result width; only 32 (IEEE 754 single) SHALL be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request pulse; accepted only in IDLE.
REQ-005 a  input  width  dividend, IEEE 754 single.
REQ-006 b  input  width  divisor, IEEE 754 single.
REQ-007 busy  output  1  high from the cycle after accept until done is asserted.
REQ-008 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-009 result  output  width  quotient a/b, IEEE 754 single.
REQ-010 div_by_zero  output  1  updated with done; high when b is zero and a is finite nonzero.

Function
REQ-011 On accept (start=1 in IDLE), a and b SHALL be registered; later input changes SHALL not affect the operation.
REQ-012 FSM states: IDLE -> DIVIDE (start) -> NORM (after 26 iterations) -> DONE (1 cycle) -> IDLE.
REQ-013 Latency: with accept at edge N, done SHALL be high for exactly the cycle after edge N+28; busy is high after edges N+1..N+27.
REQ-014 start while busy or in DONE SHALL be ignored; no queuing.
REQ-015 Sign = a[31] XOR b[31] for all results, including zero and infinity; NaN uses 0x7FC00000.
REQ-016 Mantissas: Ma = {1,a[22:0]}, Mb = {1,b[22:0]}; restoring division SHALL produce one quotient bit per DIVIDE cycle, giving the 26-bit q = floor(Ma*2^25/Mb) plus remainder rem.
REQ-017 Exponent: e = ea - eb + 127 in 10-bit signed arithmetic.
REQ-018 If q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0]|(rem!=0); else mant=q[24:1], guard=q[0], sticky=(rem!=0), e=e-1.
REQ-019 Rounding: round-to-nearest-even; increment when guard & (sticky | mant[0]); a mantissa carry-out SHALL set mant=0x800000 and e=e+1.
REQ-020 Overflow: final e >= 255 -> signed infinity (exp 0xFF, frac 0).
REQ-021 Underflow: final e <= 0 -> signed zero; no denormal outputs.
REQ-022 Inputs with exponent 0 SHALL be treated as zero (denormals flushed).
REQ-023 Specials, in priority order: any NaN input -> 0x7FC00000; 0/0 or inf/inf -> 0x7FC00000; inf/finite -> signed inf; finite/inf -> signed 0; 0/nonzero -> signed 0; nonzero finite/0 -> signed inf with div_by_zero=1.
REQ-024 Special cases SHALL use the same fixed latency as normal operands.
REQ-025 result and div_by_zero SHALL hold their last values until the next done.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, busy=0, done=0, result=0, div_by_zero=0, and clear the iteration counter and datapath registers.
REQ-027 rst_n asserted mid-operation SHALL discard the in-flight operation; no done SHALL follow it.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-029 a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result=0x40400000, div_by_zero=0, done exactly 28 edges after accept.
REQ-030 a=0x3F800000 (1.0), b=0x40400000 (3.0) -> result=0x3EAAAAAB (round-up check); a=0xBF800000, b=0x40000000 -> 0xBF000000.
REQ-031 a=0x3F800000, b=0x00000000 -> 0x7F800000, div_by_zero=1; a=0, b=0 -> 0x7FC00000, div_by_zero=0.
REQ-032 a=0x7F7FFFFF, b=0x3F000000 -> 0x7F800000 (overflow); a=0x00800000, b=0x40000000 -> 0x00000000 (underflow).
REQ-033 Pulse start again 5 cycles after accept with different operands -> ignored; the single done carries the first result.
REQ-034 Assert rst_n low 10 cycles after accept -> all outputs 0 immediately; no done; a fresh start after release completes normally.
